alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 29 ++
 rtl/alu_arbiter_alu.sv | 28 ++
 rtl/alu_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for alu_arbiter: FSM state encodings, ALU operation codes
// and the operand-register record latched on grant.
package alu_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] ALU_SUB  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_RSVD = 3'b111;

  typedef struct packed {
    logic            id;
    logic [2:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } op_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rv32ialu: single-cycle combinational RV32I-style ALU used as the arbiter datapath.
// The reserved code yields zero, so zero is asserted for it.
module rv32ialu
  import alu_arbiter_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ctrl,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_SUB: y = a - b;
      ALU_ADD: y = a + b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE grants, EXEC computes, RESP holds
// the result until rsp_ready. ALU_ARBITER_RR_EN selects round-robin over fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_b0,
  input  logic [2:0]      req_ctrl0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b1,
  input  logic [2:0]      req_ctrl1,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_y,
  output logic            rsp_zero,
  input  logic            rsp_ready,
  output logic            busy
);

  // Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
  // a result transfers on an edge where rsp_valid & rsp_ready, and is held otherwise.

  state_e          state_q, state_d;
  op_t             op_q, op_d;
  logic            rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_y_q, rsp_y_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic [1:0]      grant;
  logic [XLEN-1:0] alu_y;
  logic            alu_zero;

`ifdef ALU_ARBITER_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    if (state_q == ST_IDLE) begin
      // On a tie the requester that did not win last time goes first.
      if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
      else                    grant = req_valid;
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant != 2'b00) last_d = grant[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb begin
    grant = 2'b00;
    if (state_q == ST_IDLE) begin
      if (req_valid[0])      grant = 2'b01;
      else if (req_valid[1]) grant = 2'b10;
    end
  end
`endif

  rv32ialu u_alu (
    .a    (op_q.a),
    .b    (op_q.b),
    .ctrl (op_q.ctrl),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rsp_id_d   = rsp_id_q;
    rsp_y_d    = rsp_y_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          state_d   = ST_EXEC;
          op_d.id   = grant[1];
          op_d.ctrl = grant[1] ? req_ctrl1 : req_ctrl0;
          op_d.a    = grant[1] ? req_a1    : req_a0;
          op_d.b    = grant[1] ? req_b1    : req_b0;
        end
      end
      ST_EXEC: begin
        state_d    = ST_RESP;
        rsp_id_d   = op_q.id;
        rsp_y_d    = alu_y;
        rsp_zero_d = alu_zero;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rsp_id_q   <= 1'b0;
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rsp_id_q   <= rsp_id_d;
      rsp_y_q    <= rsp_y_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  // The registered state is already IDLE under reset; the gate keeps ready low anyway.
  assign req_ready = rst ? 2'b00 : grant;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
